// File: rtl/fib_calc.sv
// Sequential Fibonacci engine: accepts go/n, iterates one addition per cycle, presents fib(n) with done/overflow.
// Optional FIB_SATURATE_EN: clamps result to all ones when fib(n) does not fit in OUTPUT_WIDTH bits.
module fib_calc #(
  parameter int unsigned INPUT_WIDTH  = 6,
  parameter int unsigned OUTPUT_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    go,
  input  logic [INPUT_WIDTH-1:0]  n,
  output logic [OUTPUT_WIDTH-1:0] result,
  output logic                    done,
  output logic                    overflow
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_DONE    = 2'd2
  } state_e;

  localparam logic [OUTPUT_WIDTH-1:0] SAT_VAL = '1;

  state_e                  state_q, state_d;
  logic [OUTPUT_WIDTH-1:0] a_q, a_d;
  logic [OUTPUT_WIDTH-1:0] b_q, b_d;
  logic [INPUT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                    a_ovf_q, a_ovf_d;
  logic                    b_ovf_q, b_ovf_d;
  logic [OUTPUT_WIDTH-1:0] result_q, result_d;
  logic                    done_q, done_d;
  logic                    overflow_q, overflow_d;

  logic [OUTPUT_WIDTH:0]   sum_c;
  logic                    cnt_zero_c;

  // Extra MSB of the sum is the carry that marks the true value as too wide.
  assign sum_c      = {1'b0, a_q} + {1'b0, b_q};
  assign cnt_zero_c = (cnt_q == '0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; go is ignored while computing
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (go) state_d = S_COMPUTE;
      S_COMPUTE: if (cnt_zero_c) state_d = S_DONE;
      S_DONE:    if (go) state_d = S_COMPUTE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    a_d        = a_q;
    b_d        = b_q;
    cnt_d      = cnt_q;
    a_ovf_d    = a_ovf_q;
    b_ovf_d    = b_ovf_q;
    result_d   = result_q;
    done_d     = done_q;
    overflow_d = overflow_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (go) begin
          a_d     = '0;
          b_d     = OUTPUT_WIDTH'(1);
          cnt_d   = n;
          a_ovf_d = 1'b0;
          b_ovf_d = 1'b0;
          done_d  = 1'b0;
        end
      end
      S_COMPUTE: begin
        if (!cnt_zero_c) begin
          a_d     = b_q;
          b_d     = sum_c[OUTPUT_WIDTH-1:0];
          b_ovf_d = b_ovf_q | sum_c[OUTPUT_WIDTH];
          // a takes b's flag one step late so a_ovf always describes a
          a_ovf_d = b_ovf_q;
          cnt_d   = cnt_q - INPUT_WIDTH'(1);
        end else begin
`ifdef FIB_SATURATE_EN
          result_d = a_ovf_q ? SAT_VAL : a_q;
`else
          result_d = a_q;
`endif
          overflow_d = a_ovf_q;
          done_d     = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q        <= '0;
      b_q        <= OUTPUT_WIDTH'(1);
      cnt_q      <= '0;
      a_ovf_q    <= 1'b0;
      b_ovf_q    <= 1'b0;
      result_q   <= '0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      a_q        <= a_d;
      b_q        <= b_d;
      cnt_q      <= cnt_d;
      a_ovf_q    <= a_ovf_d;
      b_ovf_q    <= b_ovf_d;
      result_q   <= result_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
    end
  end

  assign result   = result_q;
  assign done     = done_q;
  assign overflow = overflow_q;

  // done mirrors the DONE state one-for-one
  a_done_matches_state : assert property (@(posedge clk) disable iff (!rst_n)
    done_q == (state_q == S_DONE));

endmodule

// File: tb/tb_fib_calc.sv
// Scoreboard bench for fib_calc: driver pushes expected fib(n) from an arithmetic model, monitor checks on done.
module tb_fib_calc;

  localparam int unsigned IW = 6;
  localparam int unsigned OW = 16;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          go    = 1'b0;
  logic [IW-1:0] n     = '0;
  logic [OW-1:0] result;
  logic          done;
  logic          overflow;

  typedef struct {
    logic [OW-1:0] res;
    logic          ovf;
    int unsigned   done_cyc;
    int unsigned   idx;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  exp_t        last_e;
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc    = 0;
  logic        done_prev = 1'b0;

  fib_calc #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .go       (go),
    .n        (n),
    .result   (result),
    .done     (done),
    .overflow (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Exact Fibonacci by plain iteration; fib(63) fits in 64 bits.
  function automatic exp_t model(input int unsigned idx, input int unsigned start_cyc);
    exp_t e;
    longint unsigned f0 = 0;
    longint unsigned f1 = 1;
    longint unsigned t;
    for (int i = 0; i < int'(idx); i++) begin
      t  = f0 + f1;
      f0 = f1;
      f1 = t;
    end
    e.ovf = ((f0 >> OW) != 0);
    e.res = OW'(f0);
`ifdef FIB_SATURATE_EN
    if (e.ovf) e.res = '1;
`endif
    e.done_cyc = start_cyc + idx + 2;
    e.idx      = idx;
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every rising done pops one expectation
  always @(negedge clk) begin
    if (rst_n && done && !done_prev) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no completion (cycle %0d)", cyc);
      end else begin
        mon_e = sb_q.pop_front();
        check($sformatf("result_n%0d", mon_e.idx), 64'(result), 64'(mon_e.res));
        check($sformatf("overflow_n%0d", mon_e.idx), 64'(overflow), 64'(mon_e.ovf));
        check($sformatf("latency_n%0d", mon_e.idx), 64'(cyc), 64'(mon_e.done_cyc));
      end
    end
    done_prev = done;
  end

  task automatic start(input int unsigned idx, input bit accepted);
    @(negedge clk);
    go = 1'b1;
    n  = IW'(idx);
    if (accepted) begin
      last_e = model(idx, cyc);
      sb_q.push_back(last_e);
    end
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic drain(input int unsigned budget);
    int unsigned k = 0;
    while (sb_q.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    int unsigned c;
    int unsigned idx;

    repeat (5) @(negedge clk);
    check("reset_result", 64'(result), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_overflow", 64'(overflow), 64'd0);
    rst_n = 1'b1;

    // Directed corner indices
    start(0, 1'b1);  drain(20);
    start(1, 1'b1);  drain(20);
    start(10, 1'b1); drain(40);
    start(24, 1'b1); drain(60);
    start(25, 1'b1); drain(60);
    start(63, 1'b1); drain(100);

    // Second go during a run is ignored; result holds the previous value meanwhile
    start(20, 1'b1);
    @(negedge clk);
    go = 1'b1;
    n  = IW'(5);
    @(negedge clk);
    go = 1'b0;
    n  = IW'(9);
    check("held_result_midrun", 64'(result), 64'(model(63, 0).res));
    check("done_low_midrun", 64'(done), 64'd0);
    drain(60);

    // go held high: one-cycle done every 5 cycles for n=3
    @(negedge clk);
    c  = cyc;
    go = 1'b1;
    n  = IW'(3);
    for (int k = 0; k < 4; k++) sb_q.push_back(model(3, c + 5 * k));
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("held_go_done_fall_%0d", k), 64'(done), 64'd0);
      repeat (4) @(negedge clk);
      check($sformatf("held_go_done_high_%0d", k), 64'(done), 64'd1);
    end
    go = 1'b0;
    drain(10);

    // Asynchronous reset mid-run aborts without a completion
    start(30, 1'b0);
    check("prev_result_during_run", 64'(result), 64'd2);
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_result", 64'(result), 64'd0);
    check("async_rst_done", 64'(done), 64'd0);
    check("async_rst_overflow", 64'(overflow), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("no_done_after_abort", 64'(done), 64'd0);
    start(7, 1'b1);
    drain(30);

    // Random indices, with stray go pulses injected into longer runs
    repeat (20) begin
      idx = $urandom_range(0, 63);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      start(idx, 1'b1);
      if (idx >= 4) start($urandom_range(0, 63), 1'b0);
      drain(100);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no end expected $finish before %0d cycles", cyc);
    $fatal(1);
  end

endmodule

// File: doc/fib_calc.md
Name: fib_calc

Overview:
- Sequential Fibonacci engine: the responder side of the go/n/result/done/overflow handshake that the team's bus-functional model drives.
- Accepts a start pulse with index n, iterates one addition per cycle, then presents fib(n) with a sticky done flag and an overflow indication.
- Top-level DUT for the lab testbench; no other submodules.

Parameters:
INPUT_WIDTH, 6, width of index n (max n = 2^INPUT_WIDTH-1)
OUTPUT_WIDTH, 16, width of result; fib values are computed modulo 2^OUTPUT_WIDTH

Ports:
clk  input  1  single clock, all state on rising edge
rst_n  input  1  asynchronous, active-low reset
go  input  1  start request, sampled on rising clk
n  input  INPUT_WIDTH  Fibonacci index, captured when go is accepted
result  output  OUTPUT_WIDTH  fib(n) of the last completed run (truncated)
done  output  1  high from completion until the next accepted go
overflow  output  1  true fib(n) did not fit in OUTPUT_WIDTH bits; valid while done=1

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; result=0, done=0, overflow=0; internal a=0, b=1, cnt=0, a_ovf=b_ovf=0.
- Reset mid-run aborts immediately; no done pulse follows.
- Definition: fib(0)=0, fib(1)=1, fib(k)=fib(k-1)+fib(k-2).
- FSM states:
  - IDLE: entered after reset. go=1 at an edge -> load a=0, b=1, cnt=n, a_ovf=b_ovf=0, go to COMPUTE.
  - COMPUTE, cnt!=0: a<=b, b<=(a+b) mod 2^OUTPUT_WIDTH, b_ovf<=b_ovf|carry, a_ovf<=b_ovf, cnt<=cnt-1.
  - COMPUTE, cnt==0: result<=a, overflow<=a_ovf, done<=1, go to DONE.
  - DONE: outputs held. go=1 -> same load as IDLE, done<=0 on that same edge, go to COMPUTE.
- Latency: go sampled at edge k -> done rises after edge k+n+1 (n=0: one cycle).
- go while in COMPUTE is ignored; n is not re-sampled.
- n is captured only at acceptance; later changes to n have no effect.
- result/overflow change only at completion. Between runs they keep the last value, including the cycles of a new run in progress.
- Overflow is sticky per run: the first carry out of the b adder marks b. The flag propagates to a one iteration later, so overflow refers exactly to fib(n).
- Back-to-back: go held high continuously restarts on each completion. done is high for exactly one cycle between runs.

Optional Feature:
- FIB_SATURATE_EN defined: at completion, if a_ovf=1 then result <= all ones (2^OUTPUT_WIDTH-1). overflow behaves identically.
- FIB_SATURATE_EN undefined: result is the modulo-2^OUTPUT_WIDTH value.

Test Plan:
- Reset for 5 cycles, release, go with n=0 -> done after 1 cycle, result=0, overflow=0. Then n=1 -> done after 2 cycles, result=1.
- go with n=10 -> done exactly 11 cycles after the go edge, result=55, overflow=0. n=24 -> result=46368, overflow=0.
- go with n=25 -> overflow=1, result=9489 (FIB_SATURATE_EN undefined) or 65535 (defined). n=63 -> overflow=1.
- go with n=20, pulse go with n=5 three cycles later -> second go ignored; result=6765 at cycle 21.
- go held high continuously with n=3 -> done high exactly 1 cycle every 5 cycles, result=2 each time. done falls on the edge that accepts the new go.
- Start n=30, drop rst_n asynchronously mid-cycle at cycle 10 -> outputs zero immediately, no done. After release, n=7 -> result=13.
